// File: rtl/cachewaysweep_pkg.sv
// Shared types for the cache way: the configuration record and the sweep FSM state.
package cachewaysweep_pkg;

    typedef struct packed {
        int unsigned CACHE_SRAMLEN;
        int unsigned CACHE_TAGPARITY;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{CACHE_SRAMLEN: 128, CACHE_TAGPARITY: 0};

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweepstate_t;

endpackage

// File: rtl/cachewaysweep_cachesweep.sv
// Invalidation sequencer: walks every set once, one set per cycle, after reset or on request.
module cachesweep
    import cachewaysweep_pkg::*;
#(
    parameter int NUMLINES = 512
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        invalidate,
    output logic [$clog2(NUMLINES)-1:0] sweep_idx,
    output logic                        busy
);

    localparam int SETW = $clog2(NUMLINES);
    localparam logic [SETW-1:0] LAST_SET = SETW'(NUMLINES - 1);

    sweepstate_t state;

    // The index only leaves the last set through the return to IDLE, never by wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SWEEP;
            sweep_idx <= '0;
            busy      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (invalidate) begin
                        state     <= SWEEP;
                        sweep_idx <= '0;
                        busy      <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (sweep_idx == LAST_SET) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        sweep_idx <= sweep_idx + SETW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/cachewaysweep.sv
// One cache way: tag, banked data, valid and dirty storage with a sequenced invalidation sweep
// and optional even parity on each stored tag.
module cachewaysweep
    import cachewaysweep_pkg::*;
#(
    parameter cvw_t P               = CVW_DEFAULT,
    parameter int   PA_BITS         = 40,
    parameter int   XLEN            = 64,
    parameter int   NUMLINES        = 512,
    parameter int   LINELEN         = 256,
    parameter int   TAGLEN          = 26,
    parameter int   OFFSETLEN       = 5,
    parameter int   INDEXLEN        = 9,
    parameter int   SRAMLEN         = int'(P.CACHE_SRAMLEN),
    parameter int   READ_ONLY_CACHE = 0,
    parameter int   TAGPARITY       = int'(P.CACHE_TAGPARITY)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        FlushStage,
    input  logic                        CacheEn,
    input  logic [$clog2(NUMLINES)-1:0] CacheSet,
    input  logic [PA_BITS-1:0]          PAdr,
    input  logic [LINELEN-1:0]          LineWriteData,
    input  logic [LINELEN/8-1:0]        LineByteMask,
    input  logic                        SetValid,
    input  logic                        SetDirty,
    input  logic                        ClearDirty,
    input  logic                        SelWriteback,
    input  logic                        SelFlush,
    input  logic                        VictimWay,
    input  logic                        FlushWay,
    input  logic                        InvalidateCache,
    output logic [LINELEN-1:0]          ReadDataLineWay,
    output logic                        HitWay,
    output logic                        ValidWay,
    output logic                        DirtyWay,
    output logic [TAGLEN-1:0]           TagWay,
    output logic                        SweepBusy,
    output logic                        TagParityErr
);

    localparam int   SETW      = $clog2(NUMLINES);
    localparam int   NUMBANKS  = LINELEN / SRAMLEN;
    localparam int   BANKBYTES = SRAMLEN / 8;
    localparam int   TAGW      = TAGLEN + ((TAGPARITY != 0) ? 1 : 0);
    localparam int   TAGLSB    = OFFSETLEN + INDEXLEN;
    localparam logic WRITABLE  = (READ_ONLY_CACHE == 0);
    localparam logic PARITY_ON = (TAGPARITY != 0);

    if ((LINELEN % SRAMLEN) != 0 || (SRAMLEN % 8) != 0 || (LINELEN % XLEN) != 0) begin : g_bad_geometry
        $error("cachewaysweep: LINELEN must be a multiple of SRAMLEN and XLEN, SRAMLEN a multiple of 8");
    end
    if ((PA_BITS - TAGLSB) != TAGLEN || (1 << INDEXLEN) != NUMLINES) begin : g_bad_address
        $error("cachewaysweep: address fields do not match TAGLEN/NUMLINES");
    end

    logic [SETW-1:0]      sweep_idx;
    logic [SETW-1:0]      state_addr;
    logic                 sel_tag;
    logic                 sel_nonhit;
    logic                 sel_data;
    logic                 write_ok;
    logic                 write_line;
    logic                 write_data;
    logic                 set_dirty_way;
    logic                 clear_dirty_way;
    logic                 write_dirty;
    logic [LINELEN/8-1:0] byte_mask;
    logic [TAGLEN-1:0]    padr_tag;
    logic [TAGLEN-1:0]    read_tag;
    logic [TAGW-1:0]      tag_mem [NUMLINES];
    logic [TAGW-1:0]      tag_q;
    logic                 stored_parity;
    logic [LINELEN-1:0]   data_q;
    logic [NUMLINES-1:0]  valid_bits;
    logic [NUMLINES-1:0]  dirty_bits;
    logic                 valid_q;
    logic                 dirty_q;
    logic                 unused_padr_bits;

    cachesweep #(
        .NUMLINES(NUMLINES)
    ) u_sweep (
        .clk       (clk),
        .reset     (reset),
        .invalidate(InvalidateCache),
        .sweep_idx (sweep_idx),
        .busy      (SweepBusy)
    );

    assign padr_tag         = PAdr[PA_BITS-1:TAGLSB];
    assign unused_padr_bits = ^PAdr[TAGLSB-1:0];

    // A read-only way is never flushed or written back, so only the victim and fill paths remain.
    always_comb begin
        if (WRITABLE) begin
            sel_tag    = SelFlush ? FlushWay : VictimWay;
            sel_nonhit = (FlushWay & SelFlush) | SetValid | SelWriteback;
        end else begin
            sel_tag    = VictimWay;
            sel_nonhit = SetValid;
        end
        sel_data = sel_nonhit ? sel_tag : HitWay;
    end

    assign write_ok        = ~FlushStage & ~SweepBusy;
    assign write_line      = SetValid & sel_data & write_ok;
    assign set_dirty_way   = SetDirty & sel_data & WRITABLE;
    assign clear_dirty_way = ClearDirty & sel_data & WRITABLE;
    assign write_data      = write_line | (set_dirty_way & write_ok);
    assign write_dirty     = (set_dirty_way | clear_dirty_way) & write_ok;
    assign byte_mask       = (SetValid | ~WRITABLE) ? '1 : LineByteMask;

    always_ff @(posedge clk) begin
        if (CacheEn) tag_q <= tag_mem[CacheSet];
        if (write_line) tag_mem[CacheSet] <= TAGW'({^padr_tag, padr_tag});
    end

    assign read_tag      = tag_q[TAGLEN-1:0];
    assign stored_parity = PARITY_ON ? tag_q[TAGW-1] : 1'b0;

    for (genvar b = 0; b < NUMBANKS; b++) begin : g_bank
        logic [SRAMLEN-1:0] bank_mem [NUMLINES];
        logic [SRAMLEN-1:0] bank_q;

        always_ff @(posedge clk) begin
            if (CacheEn) bank_q <= bank_mem[CacheSet];
            if (write_data) begin
                for (int k = 0; k < BANKBYTES; k++) begin
                    if (byte_mask[b*BANKBYTES + k])
                        bank_mem[CacheSet][k*8 +: 8] <= LineWriteData[b*SRAMLEN + k*8 +: 8];
                end
            end
        end

        assign data_q[b*SRAMLEN +: SRAMLEN] = bank_q;
    end

    // The sweep owns the valid/dirty address while busy; normal writes are already blocked then.
    assign state_addr = SweepBusy ? sweep_idx : CacheSet;

    always_ff @(posedge clk) begin
        if (SweepBusy) begin
            valid_bits[state_addr] <= 1'b0;
            dirty_bits[state_addr] <= 1'b0;
        end else begin
            if (write_line) valid_bits[state_addr] <= 1'b1;
            if (write_dirty) dirty_bits[state_addr] <= set_dirty_way;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || SweepBusy) begin
            valid_q <= 1'b0;
            dirty_q <= 1'b0;
        end else if (CacheEn) begin
            valid_q <= valid_bits[state_addr];
            dirty_q <= dirty_bits[state_addr];
        end
    end

    assign ValidWay        = valid_q & ~SweepBusy;
    assign TagParityErr    = PARITY_ON & ValidWay & (stored_parity != ^read_tag);
    assign HitWay          = ValidWay & (read_tag == padr_tag) & ~TagParityErr & ~SweepBusy;
    assign DirtyWay        = sel_tag & dirty_q & ValidWay & WRITABLE;
    assign TagWay          = sel_tag ? read_tag : '0;
    assign ReadDataLineWay = sel_data ? data_q : '0;

endmodule

// File: tb/tb_cachewaysweep.sv
// Scoreboard bench for cachewaysweep: a set-level reference model predicts every cycle's outputs.
module tb_cachewaysweep;

    localparam int NL = 8;
    localparam int LL = 64;
    localparam int TL = 8;
    localparam int PA = 14;

    typedef struct {
        bit         reset;
        bit         flush_stage;
        bit         cache_en;
        logic [2:0] set;
        logic [7:0] tag;
        logic [63:0] wdata;
        logic [7:0] mask;
        bit         set_valid;
        bit         set_dirty;
        bit         clear_dirty;
        bit         sel_wb;
        bit         sel_flush;
        bit         victim;
        bit         flush_way;
        bit         inval;
    } stim_t;

    typedef struct {
        bit          busy;
        bit          valid;
        bit          hit;
        bit          dirty;
        bit          perr;
        bit          sel_data;
        logic [7:0]  tag;
        logic [63:0] data;
        bit          tag_chk;
        bit          data_chk;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, FlushStage, CacheEn;
    logic [2:0]     CacheSet;
    logic [PA-1:0]  PAdr;
    logic [LL-1:0]  LineWriteData;
    logic [LL/8-1:0] LineByteMask;
    logic           SetValid, SetDirty, ClearDirty, SelWriteback, SelFlush, VictimWay, FlushWay;
    logic           InvalidateCache;
    logic [LL-1:0]  ReadDataLineWay;
    logic           HitWay, ValidWay, DirtyWay, SweepBusy, TagParityErr;
    logic [TL-1:0]  TagWay;

    cachewaysweep #(
        .PA_BITS(PA), .XLEN(32), .NUMLINES(NL), .LINELEN(LL), .TAGLEN(TL),
        .OFFSETLEN(3), .INDEXLEN(3), .SRAMLEN(32), .READ_ONLY_CACHE(0), .TAGPARITY(1)
    ) dut (
        .clk(clk), .reset(reset), .FlushStage(FlushStage), .CacheEn(CacheEn),
        .CacheSet(CacheSet), .PAdr(PAdr), .LineWriteData(LineWriteData),
        .LineByteMask(LineByteMask), .SetValid(SetValid), .SetDirty(SetDirty),
        .ClearDirty(ClearDirty), .SelWriteback(SelWriteback), .SelFlush(SelFlush),
        .VictimWay(VictimWay), .FlushWay(FlushWay), .InvalidateCache(InvalidateCache),
        .ReadDataLineWay(ReadDataLineWay), .HitWay(HitWay), .ValidWay(ValidWay),
        .DirtyWay(DirtyWay), .TagWay(TagWay), .SweepBusy(SweepBusy), .TagParityErr(TagParityErr)
    );

    // Reference model: per-set contents plus the snapshot held by the last enabled read.
    bit          m_valid [NL];
    bit          m_dirty [NL];
    logic [7:0]  m_tag [NL];
    logic [63:0] m_data [NL];
    bit          m_tag_known [NL];
    bit          m_data_known [NL];
    bit          m_busy = 0;
    int          m_pos = 0;
    bit          s_valid = 0, s_dirty = 0, s_tag_known = 0, s_data_known = 0;
    logic [7:0]  s_tag = '0;
    logic [63:0] s_data = '0;
    bit          parity_bad = 0;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] tag_pool [4] = '{8'h11, 8'h22, 8'h5A, 8'h33};

    function automatic exp_t predict(stim_t s);
        exp_t e;
        bit st, nonhit;
        e.busy  = m_busy;
        e.valid = s_valid && !m_busy;
        e.perr  = e.valid && parity_bad;
        e.hit   = e.valid && (s_tag == s.tag) && !e.perr;
        st      = s.sel_flush ? s.flush_way : s.victim;
        nonhit  = (s.flush_way && s.sel_flush) || s.set_valid || s.sel_wb;
        e.sel_data = nonhit ? st : e.hit;
        e.dirty    = st && s_dirty && e.valid;
        e.tag      = st ? s_tag : 8'h00;
        e.tag_chk  = !st || s_tag_known;
        e.data     = e.sel_data ? s_data : 64'h0;
        e.data_chk = !e.sel_data || s_data_known;
        return e;
    endfunction

    task automatic modelEdge(stim_t s);
        exp_t pre;
        int idx;
        pre = predict(s);
        idx = int'(s.set);
        if (s.reset || m_busy) begin
            s_valid = 0;
            s_dirty = 0;
        end else if (s.cache_en) begin
            s_valid = m_valid[idx];
            s_dirty = m_dirty[idx];
        end
        if (s.cache_en) begin
            s_tag        = m_tag[idx];
            s_data       = m_data[idx];
            s_tag_known  = m_tag_known[idx];
            s_data_known = m_data_known[idx];
        end
        if (!s.flush_stage && !m_busy && pre.sel_data) begin
            if (s.set_valid) begin
                m_tag[idx] = s.tag;
                m_tag_known[idx] = 1;
                m_valid[idx] = 1;
                m_data[idx] = s.wdata;
                m_data_known[idx] = 1;
            end else if (s.set_dirty) begin
                for (int k = 0; k < 8; k++)
                    if (s.mask[k]) m_data[idx][k*8 +: 8] = s.wdata[k*8 +: 8];
            end
            if (s.set_dirty || s.clear_dirty) m_dirty[idx] = s.set_dirty;
        end
        if (m_busy) begin
            m_valid[m_pos] = 0;
            m_dirty[m_pos] = 0;
            if (m_pos == NL - 1) m_busy = 0;
            else m_pos++;
        end else if (s.inval) begin
            m_busy = 1;
            m_pos  = 0;
        end
        if (s.reset) begin
            m_busy = 1;
            m_pos  = 0;
        end
        exp_q.push_back(predict(s));
    endtask

    task automatic applyStimulus(stim_t s);
        reset           = s.reset;
        FlushStage      = s.flush_stage;
        CacheEn         = s.cache_en;
        CacheSet        = s.set;
        PAdr            = {s.tag, s.set, 3'b000};
        LineWriteData   = s.wdata;
        LineByteMask    = s.mask;
        SetValid        = s.set_valid;
        SetDirty        = s.set_dirty;
        ClearDirty      = s.clear_dirty;
        SelWriteback    = s.sel_wb;
        SelFlush        = s.sel_flush;
        VictimWay       = s.victim;
        FlushWay        = s.flush_way;
        InvalidateCache = s.inval;
        modelEdge(s);
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(string name, logic [63:0] got, logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
        end
    endtask

    function automatic stim_t quiet();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t rd(int set, logic [7:0] tag, bit victim);
        stim_t s;
        s = quiet();
        s.cache_en = 1;
        s.set      = 3'(set);
        s.tag      = tag;
        s.victim   = victim;
        return s;
    endfunction

    function automatic stim_t fill(int set, logic [7:0] tag);
        stim_t s;
        s = rd(set, tag, 1'b1);
        s.set_valid = 1;
        s.wdata     = {$urandom, $urandom};
        return s;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("SweepBusy", 64'(SweepBusy), 64'(e.busy));
                checkOutput("ValidWay", 64'(ValidWay), 64'(e.valid));
                checkOutput("HitWay", 64'(HitWay), 64'(e.hit));
                checkOutput("DirtyWay", 64'(DirtyWay), 64'(e.dirty));
                checkOutput("TagParityErr", 64'(TagParityErr), 64'(e.perr));
                if (e.tag_chk) checkOutput("TagWay", 64'(TagWay), 64'(e.tag));
                if (e.data_chk) checkOutput("ReadDataLineWay", ReadDataLineWay, e.data);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: run exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        stim_t s;
        @(negedge clk);
        #1;

        // Reset, full sweep of 8 sets, then every set reads invalid.
        s = quiet();
        s.reset = 1;
        applyStimulus(s);
        applyStimulus(s);
        repeat (9) applyStimulus(quiet());
        for (int i = 0; i < NL; i++) applyStimulus(rd(i, 8'h00, 1'b1));

        // Fill set 3 with tag 0x5A and hit on it.
        applyStimulus(fill(3, 8'h5A));
        applyStimulus(rd(3, 8'h5A, 1'b1));

        // Partial store of bytes 0-3, then clear the dirty bit.
        s = quiet();
        s.set = 3'd3;
        s.tag = 8'h5A;
        s.set_dirty = 1;
        s.mask = 8'h0F;
        s.wdata = {$urandom, $urandom};
        applyStimulus(s);
        applyStimulus(rd(3, 8'h5A, 1'b1));
        s = quiet();
        s.set = 3'd3;
        s.tag = 8'h5A;
        s.clear_dirty = 1;
        applyStimulus(s);
        applyStimulus(rd(3, 8'h5A, 1'b1));

        // Invalidate with sets 0 and 7 valid; a fill during the sweep is dropped.
        applyStimulus(fill(0, 8'h11));
        applyStimulus(fill(7, 8'h22));
        s = quiet();
        s.inval = 1;
        applyStimulus(s);
        for (int i = 0; i < NL; i++) begin
            if (i == 2) applyStimulus(fill(5, 8'h44));
            else applyStimulus(quiet());
        end
        applyStimulus(rd(0, 8'h11, 1'b1));
        applyStimulus(rd(7, 8'h22, 1'b1));
        applyStimulus(rd(5, 8'h44, 1'b1));

        // Corrupted stored parity suppresses the hit.
        applyStimulus(fill(2, 8'h33));
        applyStimulus(rd(2, 8'h33, 1'b1));
        force dut.stored_parity = 1'b1;
        parity_bad = 1;
        s = rd(2, 8'h33, 1'b1);
        s.cache_en = 0;
        applyStimulus(s);
        applyStimulus(rd(2, 8'h33, 1'b1));
        release dut.stored_parity;
        parity_bad = 0;
        applyStimulus(rd(2, 8'h33, 1'b1));

        // Reset on sweep cycle 4 restarts the sweep; a fill under FlushStage is dropped.
        s = quiet();
        s.inval = 1;
        applyStimulus(s);
        repeat (4) applyStimulus(quiet());
        s = quiet();
        s.reset = 1;
        applyStimulus(s);
        repeat (9) applyStimulus(quiet());
        s = fill(4, 8'h66);
        s.flush_stage = 1;
        applyStimulus(s);
        applyStimulus(rd(4, 8'h66, 1'b1));

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            s = quiet();
            s.reset       = ($urandom_range(149) == 0);
            s.inval       = ($urandom_range(39) == 0);
            s.flush_stage = ($urandom_range(7) == 0);
            s.cache_en    = ($urandom_range(3) != 0);
            s.set         = 3'($urandom_range(7));
            s.tag         = tag_pool[$urandom_range(3)];
            s.wdata       = {$urandom, $urandom};
            s.mask        = 8'($urandom);
            s.set_valid   = ($urandom_range(3) == 0);
            s.set_dirty   = ($urandom_range(3) == 0);
            s.clear_dirty = ($urandom_range(5) == 0);
            s.sel_wb      = ($urandom_range(7) == 0);
            s.sel_flush   = ($urandom_range(5) == 0);
            s.victim      = ($urandom_range(1) == 0);
            s.flush_way   = ($urandom_range(1) == 0);
            applyStimulus(s);
        end

        applyStimulus(quiet());
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) checkOutput("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
